// File: rtl/uart_transmit_pkg.sv
// rtl/uart_transmit_pkg.sv - shared UART constants, FSM state encoding and sizing helper
package uart_transmit_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 26;
    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam logic START_LEVEL          = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A one-cycle bit period still needs a one-bit timer register.
    function automatic int timer_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_transmit_counter.sv
// rtl/uart_transmit_counter.sv - modulo-N enable counter with wrap strobe, used as the bit timer
module uart_transmit_counter #(
    parameter int MODULO = 26,
    parameter int WIDTH  = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    output logic WRAP
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count;

    assign WRAP = EN && (count == LAST);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            count <= '0;
        end else if (EN) begin
            count <= WRAP ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with first-word fall-through read port
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR,
    input  logic [7:0] DIN,
    input  logic       RD,
    output logic [7:0] DOUT,
    output logic       FULL,
    output logic       EMPTY
);

    localparam int             PW          = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    DEPTH_COUNT = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    assign FULL  = (count == DEPTH_COUNT);
    assign EMPTY = (count == '0);
    assign push  = WR && !FULL;
    assign pop   = RD && !EMPTY;
    assign DOUT  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= DIN;
    end

endmodule

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - FIFO-buffered 8N1 serial transmitter with back-to-back framing
module uart_transmit
    import uart_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       WR,
    output logic       FULL,
    output logic       OVERRUN,
    output logic       BUSY,
    output logic       TXD
);

    localparam int TW = timer_width(CLKS_PER_BIT);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_next;
    logic       txd_next;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       timer_en;
    logic       timer_wrap;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .WR    (WR),
        .DIN   (DATA),
        .RD    (fifo_rd),
        .DOUT  (fifo_dout),
        .FULL  (FULL),
        .EMPTY (fifo_empty)
    );

    assign timer_en = (state != ST_IDLE);

    uart_transmit_counter #(
        .MODULO (CLKS_PER_BIT),
        .WIDTH  (TW)
    ) u_bit_timer (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (!timer_en),
        .EN   (timer_en),
        .WRAP (timer_wrap)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        fifo_rd      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd      = 1'b1;
                    shift_next   = fifo_dout;
                    bit_idx_next = '0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (timer_wrap) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (timer_wrap) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Chaining straight into the next start bit keeps bursts gap-free.
                if (timer_wrap) begin
                    if (!fifo_empty) begin
                        fifo_rd      = 1'b1;
                        shift_next   = fifo_dout;
                        bit_idx_next = '0;
                        state_next   = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line level is computed for the upcoming state so TXD comes straight off a flop.
    always_comb begin
        txd_next = IDLE_LEVEL;
        case (state_next)
            ST_START: txd_next = START_LEVEL;
            ST_DATA:  txd_next = shift_next[0];
            default:  txd_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            TXD     <= IDLE_LEVEL;
            OVERRUN <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            TXD     <= txd_next;
            OVERRUN <= WR && FULL;
        end
    end

    assign BUSY = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - directed self-checking bench for uart_transmit with a line decoder
module tb_uart_transmit;

    localparam int CPB = 26;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA = 8'h00;
    logic       WR = 1'b0;
    logic       FULL;
    logic       OVERRUN;
    logic       BUSY;
    logic       TXD;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         m_err = 0;
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    int         m_slot = 0;
    logic [7:0] m_byte = 8'h00;

    uart_transmit #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .DATA    (DATA),
        .WR      (WR),
        .FULL    (FULL),
        .OVERRUN (OVERRUN),
        .BUSY    (BUSY),
        .TXD     (TXD)
    );

    always #5 CLK = ~CLK;

    // Independent receiver: samples mid-bit from the detected falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (TXD === 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                m_slot = m_cnt / CPB;
                if (m_slot == 0) begin
                    if (TXD !== 1'b0) m_err++;
                end else if (m_slot <= 8) begin
                    m_byte[m_slot-1] = TXD;
                end else begin
                    if (TXD !== 1'b1) m_err++;
                    rx_q.push_back(m_byte);
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (rx_q.size() > i) ? {24'h0, rx_q[i]} : 32'hDEAD;
    endfunction

    // Called on the cycle TXD first reads 0; returns on the cycle after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic exp_bit;
        int   hits;
        logic busy_last;
        for (int i = 0; i < 10; i++) begin
            exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            hits = 0;
            for (int c = 0; c < CPB; c++) begin
                if (TXD === exp_bit) hits++;
                busy_last = BUSY;
                tick();
            end
            check($sformatf("%s_bit%0d_cycles", tag, i), hits, CPB);
        end
        check({tag, "_busy_last_stop_cycle"}, busy_last, 1'b1);
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (TXD !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, TXD, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, BUSY, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;
        check("reset_txd", TXD, 1'b1);
        check("reset_full", FULL, 1'b0);
        check("reset_overrun", OVERRUN, 1'b0);
        check("reset_busy", BUSY, 1'b0);

        // Single byte: start edge two cycles after the write
        DATA = 8'h55;
        WR   = 1'b1;
        tick();
        WR   = 1'b0;
        check("single_txd_n1", TXD, 1'b1);
        check("single_busy_n1", BUSY, 1'b1);
        tick();
        check("single_txd_n2", TXD, 1'b0);
        check_frame("single", 8'h55);
        check("single_busy_drop", BUSY, 1'b0);
        check("single_txd_idle", TXD, 1'b1);
        check("single_rx_count", rx_q.size(), 1);
        check("single_rx_byte", rx_at(0), 32'h55);

        // Back-to-back: no idle gap between frames
        rx_q.delete();
        DATA = 8'hA5;
        WR   = 1'b1;
        tick();
        DATA = 8'h3C;
        tick();
        WR   = 1'b0;
        check("b2b_first_fall", TXD, 1'b0);
        check_frame("b2b_a5", 8'hA5);
        check("b2b_second_fall_at_260", TXD, 1'b0);
        check_frame("b2b_3c", 8'h3C);
        check("b2b_busy_drop", BUSY, 1'b0);
        check("b2b_rx_count", rx_q.size(), 2);
        check("b2b_rx0", rx_at(0), 32'hA5);
        check("b2b_rx1", rx_at(1), 32'h3C);

        // Overflow: six writes into a depth-4 FIFO, one byte popped immediately
        rx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            DATA = 8'(i);
            WR   = 1'b1;
            tick();
            if (i == 4) check("ovf_not_full_at_3", FULL, 1'b0);
            if (i == 5) check("ovf_full_at_4", FULL, 1'b1);
            if (i == 5) check("ovf_no_overrun_yet", OVERRUN, 1'b0);
        end
        WR = 1'b0;
        check("ovf_overrun_pulse", OVERRUN, 1'b1);
        check("ovf_full_held", FULL, 1'b1);
        tick();
        check("ovf_overrun_one_cycle", OVERRUN, 1'b0);
        check("ovf_full_still", FULL, 1'b1);
        wait_idle("ovf_idle_timeout", 6 * 10 * CPB);
        check("ovf_full_clear", FULL, 1'b0);
        check("ovf_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_rx%0d", i), rx_at(i), 32'(i + 1));
        end

        // Reset mid-frame during data bit 3 of 0xFF
        rx_q.delete();
        DATA = 8'hFF;
        WR   = 1'b1;
        tick();
        WR   = 1'b0;
        wait_fall("rst_first_fall");
        repeat (4 * CPB + 10) tick();
        check("rst_in_data_bit3", TXD, 1'b1);
        check("rst_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_txd", TXD, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_full", FULL, 1'b0);
        tick();
        check("rst_txd_stays_idle", TXD, 1'b1);
        DATA = 8'h00;
        WR   = 1'b1;
        tick();
        WR   = 1'b0;
        tick();
        check("rst_new_fall", TXD, 1'b0);
        check_frame("rst_00", 8'h00);
        check("rst_rx_count", rx_q.size(), 1);
        check("rst_rx_byte", rx_at(0), 32'h00);

        // Loopback burst through the decoder
        rx_q.delete();
        DATA = 8'h00; WR = 1'b1; tick();
        DATA = 8'hFF; tick();
        DATA = 8'h5A; tick();
        DATA = 8'h81; tick();
        WR = 1'b0;
        wait_idle("loop_idle_timeout", 5 * 10 * CPB);
        check("loop_rx_count", rx_q.size(), 4);
        check("loop_rx0", rx_at(0), 32'h00);
        check("loop_rx1", rx_at(1), 32'hFF);
        check("loop_rx2", rx_at(2), 32'h5A);
        check("loop_rx3", rx_at(3), 32'h81);
        check("line_framing_errors", m_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
